calc_sequencer: RTL and testbench

Top-level operation sequencer for the FPGA calculator. Steps the user through operand A, operand B and operator entry on each press of the progress button. Launches the multi-cycle ALU with a start/done handshake and captures the result. It also handles error and timeout recovery, and chains the previous result into the next calculation as operand A.

---
 rtl/calc_sequencer_if.sv | 27 ++
 rtl/calc_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// calc_sequencer_if : start/done handshake and operand bus to the ALU
// Revision: 1.0
// ============================================================================
interface calc_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             alu_start;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [1:0]       opcode;
  logic             alu_done;
  logic             alu_err;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_start, opa, opb, opcode,
    input  alu_done, alu_err, alu_result
  );

  modport slave (
    input  alu_start, opa, opb, opcode,
    output alu_done, alu_err, alu_result
  );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// calc_sequencer : button-driven operand/operator entry, ALU launch and capture
// Revision: 1.0
// ============================================================================
module calc_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              progress,
  input  logic              clear,
  input  logic [WIDTH-1:0]  sw,
  input  logic [1:0]        op_sel,
  calc_sequencer_if.master  alu,
  output logic [2:0]        phase,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  output logic              err,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_LOAD_OP = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_SHOW    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic [2:0]       state_q,   state_d;
  logic             prog_q,    prog_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             pend_q,    pend_d;
  logic [WIDTH-1:0] opa_q,     opa_d;
  logic [WIDTH-1:0] opb_q,     opb_d;
  logic [1:0]       opcode_q,  opcode_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             timeout_q, timeout_d;

  logic press;
  logic busy;
  logic wait_exit;
  logic clear_now;

  assign press     = progress & ~prog_q;
  assign busy      = (state_q == S_EXEC) || (state_q == S_WAIT);
  assign wait_exit = alu.alu_done || (cnt_q == CNT_LAST);
  assign clear_now = pend_q | clear;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prog_q    <= 1'b1;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      opcode_q  <= 2'b00;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opcode_q  <= opcode_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    prog_d    = progress;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opcode_d  = opcode_q;
    result_d  = result_q;
    timeout_d = timeout_q;

    if (clear && !busy) begin
      state_d   = S_LOAD_A;
      opa_d     = '0;
      opb_d     = '0;
      opcode_d  = 2'b00;
      result_d  = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press) state_d = S_LOAD_A;
        end
        S_LOAD_A: begin
          if (press) begin
            opa_d   = sw;
            state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (press) begin
            opb_d   = sw;
            state_d = S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (press) begin
            opcode_d = op_sel;
            state_d  = S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_d   = '0;
          pend_d  = clear;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A clear seen while busy is honoured only once the ALU has finished or timed out
          if (wait_exit) begin
            pend_d = 1'b0;
            if (clear_now) begin
              state_d   = S_LOAD_A;
              opa_d     = '0;
              opb_d     = '0;
              opcode_d  = 2'b00;
              result_d  = '0;
              timeout_d = 1'b0;
            end else if (alu.alu_done && !alu.alu_err) begin
              result_d = alu.alu_result;
              state_d  = S_SHOW;
            end else begin
              timeout_d = ~alu.alu_done;
              state_d   = S_ERR;
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            pend_d = clear_now;
          end
        end
        S_SHOW: begin
          if (press) begin
            opa_d   = result_q;
            state_d = S_LOAD_B;
          end
        end
        S_ERR: begin
          if (press) begin
            timeout_d = 1'b0;
            state_d   = S_LOAD_A;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    alu.alu_start = 1'b0;
    phase         = 3'b000;
    result_valid  = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_LOAD_A:  phase         = 3'b001;
      S_LOAD_B:  phase         = 3'b010;
      S_LOAD_OP: phase         = 3'b100;
      S_EXEC:    alu.alu_start = 1'b1;
      S_SHOW:    result_valid  = 1'b1;
      S_ERR:     err           = 1'b1;
      default:   phase         = 3'b000;
    endcase
  end

  assign alu.opa    = opa_q;
  assign alu.opb    = opb_q;
  assign alu.opcode = opcode_q;
  assign result     = result_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_calc_sequencer : vector table plus scoreboard bench for calc_sequencer
// Revision: 1.0
// ============================================================================
module tb_calc_sequencer;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             progress;
  logic             clear;
  logic [WIDTH-1:0] sw;
  logic [1:0]       op_sel;
  logic [2:0]       phase;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             err;
  logic             timeout;

  calc_sequencer_if #(.WIDTH(WIDTH)) alu_if ();

  calc_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .progress     (progress),
    .clear        (clear),
    .sw           (sw),
    .op_sel       (op_sel),
    .alu          (alu_if.master),
    .phase        (phase),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chain;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    int         delay;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       err;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press();
    progress = 1'b1;
    @(negedge clk);
    progress = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"},  32'(phase),            0);
    chk({tag, "_start"},  32'(alu_if.alu_start), 0);
    chk({tag, "_opa"},    32'(alu_if.opa),       0);
    chk({tag, "_opb"},    32'(alu_if.opb),       0);
    chk({tag, "_opcode"}, 32'(alu_if.opcode),    0);
    chk({tag, "_result"}, 32'(result),           0);
    chk({tag, "_rvalid"}, 32'(result_valid),     0);
    chk({tag, "_err"},    32'(err),              0);
    chk({tag, "_tmo"},    32'(timeout),          0);
  endtask

  // Behavioural ALU: reacts to whatever operands the sequencer presents
  function automatic void alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                 output logic [7:0] r, output logic e);
    e = 1'b0;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * b;
      default: begin
        if (b == 8'd0) begin
          r = 8'hFF;
          e = 1'b1;
        end else begin
          r = a / b;
        end
      end
    endcase
  endfunction

  // Starts at LOAD_A (chain=0) or SHOW (chain=1); ends at the EXEC-cycle negedge
  task automatic enter_ops(input logic chain, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op, input logic [7:0] exp_a);
    if (!chain) sw = a;
    press();
    chk("phase_b", 32'(phase), 3'b010);
    chk("rvalid_drop", 32'(result_valid), 0);
    tick();
    sw = b;
    press();
    chk("phase_op", 32'(phase), 3'b100);
    tick();
    op_sel = op;
    press();
    chk("alu_start", 32'(alu_if.alu_start), 1);
    chk("opa", 32'(alu_if.opa), 32'(exp_a));
    chk("opb", 32'(alu_if.opb), 32'(b));
    chk("opcode", 32'(alu_if.opcode), 32'(op));
    chk("phase_exec", 32'(phase), 0);
  endtask

  // Moves into WAIT, idles `delay` WAIT cycles, then pulses done
  task automatic alu_respond(input int delay);
    logic [7:0] r;
    logic       e;
    tick();
    chk("start_single", 32'(alu_if.alu_start), 0);
    repeat (delay) tick();
    alu_fn(alu_if.opa, alu_if.opb, alu_if.opcode, r, e);
    alu_if.alu_done   = 1'b1;
    alu_if.alu_err    = e;
    alu_if.alu_result = r;
    tick();
    alu_if.alu_done   = 1'b0;
    alu_if.alu_err    = 1'b0;
    alu_if.alu_result = 8'hA5;
  endtask

  task automatic check_outcome();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("result", 32'(result), 32'(e.res));
      chk("result_valid", 32'(result_valid), 32'(!e.err));
      chk("err", 32'(err), 32'(e.err));
      chk("timeout_clr", 32'(timeout), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_a;
    vecs[0] = '{1'b0, 8'd5,   8'd3,   2'd0, 4, 8'd8,   1'b0};
    vecs[1] = '{1'b1, 8'd0,   8'd2,   2'd2, 0, 8'd16,  1'b0};
    vecs[2] = '{1'b1, 8'd0,   8'd7,   2'd1, 1, 8'd9,   1'b0};
    vecs[3] = '{1'b1, 8'd0,   8'd0,   2'd3, 3, 8'd9,   1'b1};
    vecs[4] = '{1'b0, 8'd200, 8'd100, 2'd0, 2, 8'd44,  1'b0};
    vecs[5] = '{1'b1, 8'd0,   8'd5,   2'd3, 7, 8'd8,   1'b0};
    vecs[6] = '{1'b1, 8'd0,   8'd10,  2'd1, 5, 8'd254, 1'b0};
    vecs[7] = '{1'b1, 8'd0,   8'd2,   2'd2, 0, 8'd252, 1'b0};

    reset = 1'b1; progress = 1'b1; clear = 1'b0; sw = '0; op_sel = 2'b00;
    alu_if.alu_done = 1'b0; alu_if.alu_err = 1'b0; alu_if.alu_result = '0;
    repeat (3) tick();
    check_zero("reset");

    // Button held through reset release must not count as a press
    reset = 1'b0;
    repeat (3) tick();
    chk("hold_idle", 32'(phase), 0);
    progress = 1'b0;
    tick();
    chk("idle_after_release", 32'(phase), 0);
    press();
    chk("idle_to_a", 32'(phase), 3'b001);
    tick();

    alu_if.alu_done = 1'b1; alu_if.alu_result = 8'd77;
    tick();
    alu_if.alu_done = 1'b0;
    chk("done_ignored_result", 32'(result), 0);
    chk("done_ignored_phase", 32'(phase), 3'b001);

    for (int i = 0; i < 8; i++) begin
      if (i > 0 && !vecs[i].chain) begin
        press();
        chk("err_release", 32'(err), 0);
        chk("err_to_a", 32'(phase), 3'b001);
        tick();
      end
      exp_a = vecs[i].chain ? vecs[i-1].exp_res : vecs[i].a;
      enter_ops(vecs[i].chain, vecs[i].a, vecs[i].b, vecs[i].op, exp_a);
      sb.push_back('{vecs[i].exp_res, vecs[i].exp_err});
      alu_respond(vecs[i].delay);
      check_outcome();
    end

    // Timeout: no done for TIMEOUT WAIT cycles
    enter_ops(1'b1, 8'd0, 8'd1, 2'd0, 8'd252);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_early", 32'(err), 0);
    tick();
    chk("tmo_err", 32'(err), 1);
    chk("tmo_flag", 32'(timeout), 1);
    chk("tmo_result_kept", 32'(result), 252);
    press();
    chk("tmo_release_err", 32'(err), 0);
    chk("tmo_release_flag", 32'(timeout), 0);
    chk("tmo_release_phase", 32'(phase), 3'b001);
    tick();

    // Done coinciding with the terminal count wins
    enter_ops(1'b0, 8'd20, 8'd22, 2'd0, 8'd20);
    sb.push_back('{8'd42, 1'b0});
    alu_respond(TIMEOUT - 1);
    check_outcome();

    // Deferred clear during WAIT
    enter_ops(1'b1, 8'd0, 8'd5, 2'd2, 8'd42);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("wait_opa_stable", 32'(alu_if.opa), 42);
    repeat (9) begin
      chk("defer_no_valid", 32'(result_valid), 0);
      tick();
    end
    alu_if.alu_done = 1'b1; alu_if.alu_result = 8'd210;
    tick();
    alu_if.alu_done = 1'b0;
    chk("defer_phase", 32'(phase), 3'b001);
    chk("defer_opa", 32'(alu_if.opa), 0);
    chk("defer_opb", 32'(alu_if.opb), 0);
    chk("defer_opcode", 32'(alu_if.opcode), 0);
    chk("defer_result", 32'(result), 0);
    chk("defer_rvalid", 32'(result_valid), 0);

    // Clear beats a simultaneous press in LOAD_B
    tick();
    sw = 8'd7;
    press();
    chk("cp_phase_b", 32'(phase), 3'b010);
    chk("cp_opa_loaded", 32'(alu_if.opa), 7);
    tick();
    sw = 8'd9; clear = 1'b1; progress = 1'b1;
    tick();
    clear = 1'b0; progress = 1'b0;
    chk("cp_phase", 32'(phase), 3'b001);
    chk("cp_opa", 32'(alu_if.opa), 0);
    chk("cp_opb", 32'(alu_if.opb), 0);

    // Reset in the middle of WAIT, then a stray done
    tick();
    enter_ops(1'b0, 8'd3, 8'd4, 2'd2, 8'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst_wait");
    alu_if.alu_done = 1'b1; alu_if.alu_result = 8'd12;
    tick();
    alu_if.alu_done = 1'b0;
    tick();
    check_zero("rst_stray_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
